// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the front-end pipeline control logic.
package pipe_ctrl_pkg;

    // Fetch sequencer states; the encoding is visible to debug tooling.
    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } fetch_state_e;

    // PC source select values.
    localparam logic PC_PLUS4  = 1'b0;
    localparam logic PC_BRANCH = 1'b1;

    // addi x0, x0, 0 -- loaded by the datapath when a stage is flushed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment until all ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end sequencing controller: arbitrates redirects, load-use stalls,
// instruction-memory wait states and halt requests for the IF stage.
module fetch_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             imem_ready_i,
    input  logic             load_use_hazard_i,
    input  logic             branch_taken_i,
    input  logic             halt_req_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pc_src_o,
    output logic             imem_req_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    fetch_state_e      state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              stall_inc;
    logic              flush_inc;

    // State and boot-hold registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_BOOT;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state decode following the fixed redirect > halt > hazard > memory priority.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_BOOT: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (branch_taken_i) begin
                    state_d = ST_RUN;
                end else if (halt_req_i && (state_q == ST_RUN)) begin
                    state_d = ST_HALT;
                end else if (load_use_hazard_i) begin
                    state_d = state_q;
                end else if (!imem_ready_i) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Control output decode, zero latency from the hazard/redirect inputs.
    always_comb begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pc_src_o       = PC_PLUS4;
        imem_req_o     = 1'b0;
        halted_o       = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end
            ST_RUN, ST_MEM_WAIT: begin
                imem_req_o = 1'b1;
                if (branch_taken_i) begin
                    pc_write_o     = 1'b1;
                    pc_src_o       = PC_BRANCH;
                    if_id_flush_o  = 1'b1;
                    id_ex_bubble_o = 1'b1;
                    flush_inc      = 1'b1;
                end else if (halt_req_i && (state_q == ST_RUN)) begin
                    imem_req_o     = 1'b0;
                    id_ex_bubble_o = 1'b1;
                end else if (load_use_hazard_i || !imem_ready_i) begin
                    id_ex_bubble_o = 1'b1;
                    stall_inc      = 1'b1;
                end else begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                end
            end
            ST_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end
        endcase
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (1'b0),
        .inc_i   (stall_inc),
        .count_o (stall_count_o)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (1'b0),
        .inc_i   (flush_inc),
        .count_o (flush_count_o)
    );

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Front-end sequencing controller for the pipelined RISC-V core. Drives the IF stage's `pc_write` / `if_id_write` enables, the PC source select and the IF/ID and ID/EX kill signals. It arbitrates between branch redirects, load-use stalls, instruction-memory wait states and halt requests, and keeps saturating stall and flush counters for performance debug.

## Interface
- `RESET_HOLD`, 2: cycles held in BOOT after reset release before the first fetch (≥1)
- `CNT_W`, 16: width of the performance counters
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `imem_ready`  in  1  instruction word at the current PC is valid this cycle
- `load_use_hazard`  in  1  ID-stage load-use hazard detected
- `branch_taken`  in  1  EX resolved a taken branch/jump; target is on the datapath
- `halt_req`  in  1  ID decoded ecall/ebreak
- `pc_write`  out  1  PC register enable
- `if_id_write`  out  1  IF/ID register enable
- `if_id_flush`  out  1  load a NOP into IF/ID
- `id_ex_bubble`  out  1  load a NOP into ID/EX
- `pc_src`  out  1  0 = PC+4, 1 = branch target
- `imem_req`  out  1  fetch request to instruction memory
- `halted`  out  1  core halted
- `stall_count`  out  CNT_W  cycles with `pc_write` = 0 in RUN/MEM_WAIT (saturating)
- `flush_count`  out  CNT_W  number of taken redirects (saturating)

## Operation
- States: BOOT, RUN, MEM_WAIT, HALT. State and counters are registered; control outputs are a combinational decode of state plus inputs.
- **BOOT:** `pc_write` = 0, `if_id_write` = 0, `if_id_flush` = 1, `id_ex_bubble` = 1, `imem_req` = 0. A hold counter runs for RESET_HOLD cycles, then the state moves to RUN.
- **RUN / MEM_WAIT:** `imem_req` = 1. Evaluate in this fixed priority:
  1. `branch_taken`: `pc_write` = 1, `pc_src` = 1, `if_id_flush` = 1, `id_ex_bubble` = 1, `flush_count`++. Next state is RUN. This overrides every other input in the same cycle, because the younger instructions are wrong-path.
  2. `halt_req` (RUN only): all enables 0, `imem_req` = 0, `id_ex_bubble` = 1. Next state is HALT.
  3. `load_use_hazard`: `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1, `stall_count`++. State is unchanged.
  4. `!imem_ready`: `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1, `stall_count`++. Next state is MEM_WAIT.
  5. Otherwise: `pc_write` = 1, `if_id_write` = 1, `pc_src` = 0. Next state is RUN.
- **MEM_WAIT:** `imem_ready` returns the state to RUN through rule 5. A redirect during MEM_WAIT updates the PC; memory restarts on the new PC, and the next state is RUN.
- **HALT:** all enables 0, `imem_req` = 0, `halted` = 1. The only exit is reset.
- **Counters:** saturate at 2^CNT_W−1 and never wrap.
- **Reset:** asserting `reset` at any time forces BOOT, the hold counter to 0, both performance counters to 0 and `halted` to 0 immediately (asynchronously).

## Timing
- Output values while reset is active are the BOOT values: `if_id_flush` = 1, `id_ex_bubble` = 1, all other outputs 0.
- After `reset` deasserts, the first RESET_HOLD rising edges stay in BOOT. `pc_write` is first 1 in the following cycle, provided `imem_ready` = 1.
- Control outputs have zero latency from their inputs (combinational).
- Counters update on the rising edge that ends the qualifying cycle. The new value is visible in the next cycle.
- A redirect takes effect at the same edge: the PC loads the target and IF/ID and ID/EX receive NOPs.
- A load-use hazard stalls for exactly as many cycles as the input is asserted.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum (BOOT = 0, RUN = 1, MEM_WAIT = 2, HALT = 3)
  - the `pc_src` constants PC_PLUS4 = 0 and PC_BRANCH = 1
  - the NOP encoding 32'h00000013, used by the datapath flush logic
- One sub-module, `sat_counter` (parameterised width, `inc`, synchronous clear, async active-low reset), instantiated twice for `stall_count` and `flush_count`.
- Target size is about 150–250 lines of RTL.

## Test plan
- **Reset/boot:** hold `reset` low 3 cycles, release with `imem_ready` = 1 → `pc_write` = 0 for exactly 2 cycles, then 1; counters = 0.
- **Load-use:** `load_use_hazard` high 1 cycle in RUN → `pc_write` = `if_id_write` = 0, `id_ex_bubble` = 1 for that cycle; `stall_count` = 1.
- **Memory wait:** `imem_ready` low 3 cycles → state MEM_WAIT, `stall_count` = 3, fetch resumes the cycle `imem_ready` returns.
- **Branch vs stall:** `branch_taken` = 1 with `load_use_hazard` = 1 and `halt_req` = 1 → `pc_src` = 1, `pc_write` = 1, both flushes asserted, no HALT; `flush_count` = 1, `stall_count` unchanged.
- **Halt:** `halt_req` in RUN → `halted` = 1, `imem_req` = 0 indefinitely. Mid-HALT reset → BOOT, `halted` = 0.
- **Saturation:** CNT_W = 4, 20 stall cycles → `stall_count` stays 15.
